pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Consumes per-cycle hazard and memory-wait indications and drives the pipeline register enables, bubble and flush controls for the 5-stage CPU. It takes LOAD_USE_HAZARD from the hazard detection unit, busy flags from the I/D caches, and branch resolution from S3. It arbitrates them by fixed priority, tracks a wrong-path fetch pending behind an I-cache miss, and watchdogs D-cache freezes.

Parameters:
MAX_FREEZE, 255, number of consecutive D-cache freeze cycles after which TIMEOUT is raised.
FRZ_CNT_WIDTH, 8, width of the freeze counter; must hold MAX_FREEZE.

Ports:
CLK  input  1  pipeline clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
LOAD_USE_HAZARD  input  1  load-use hazard between S2 and S3, combinational from hazard detection unit
BRANCH_TAKEN_S3  input  1  branch/jump resolved taken in S3; PC loads target this cycle if PC_EN=1
ICACHE_BUSY  input  1  instruction fetch not complete this cycle
DCACHE_BUSY  input  1  data memory access in S4 not complete this cycle
PC_EN  output  1  PC register write enable
IF_ID_EN  output  1  S1/S2 pipeline register enable
ID_EX_EN  output  1  S2/S3 register enable
EX_MEM_EN  output  1  S3/S4 register enable
MEM_WB_EN  output  1  S4/S5 register enable
IF_ID_FLUSH  output  1  load NOP into S1/S2 register (requires IF_ID_EN=1)
ID_EX_BUBBLE  output  1  load NOP (all control bits 0) into S2/S3 register
TIMEOUT  output  1  sticky D-cache freeze watchdog flag
LU_STALL_CNT  output  32  load-use stall cycles (optional feature)
FREEZE_TOTAL_CNT  output  32  D-cache freeze cycles (optional feature)
FLUSH_CNT  output  32  branch flushes (optional feature)

Behaviour:
- Control outputs are combinational from the inputs and internal state. This gives same-cycle response to LOAD_USE_HAZARD. State: flush_pending (1b), frz_cnt, TIMEOUT, and optional counters.
- RESET=1: all five enables 1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1 (pipeline fills with NOPs). At the next edge: flush_pending=0, frz_cnt=0, TIMEOUT=0, counters=0. Reset mid-freeze or mid-pending discards that state.
- Priority per cycle, highest first:
  - P1 DCACHE_BUSY=1: all enables 0, FLUSH=0, BUBBLE=0. Branch and load-use are ignored this cycle; they stay asserted because S3 is frozen and are serviced on the release cycle.
  - P2 BRANCH_TAKEN_S3=1: all enables 1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, LOAD_USE_HAZARD ignored (wrong path). If ICACHE_BUSY=1, set flush_pending at the edge.
  - P3 LOAD_USE_HAZARD=1: PC_EN=0, IF_ID_EN=0, ID_EX_BUBBLE=1, ID_EX_EN/EX_MEM_EN/MEM_WB_EN=1. Exactly one bubble per hazard, because the load advances to S4.
  - P4 ICACHE_BUSY=1: PC_EN=0, IF_ID_EN=1, IF_ID_FLUSH=1, rest 1.
  - Default: all enables 1, FLUSH=0, BUBBLE=0.
- flush_pending:
  - While set and not in P1, IF_ID_FLUSH is forced to 1.
  - Clears at the edge of the first cycle with ICACHE_BUSY=0 and DCACHE_BUSY=0. That cycle still flushes, squashing the wrong-path instruction returned by the aborted fetch.
  - A set and a clear condition in the same cycle leave it set.
- frz_cnt:
  - Increments, saturating at MAX_FREEZE, on each DCACHE_BUSY=1 cycle.
  - Resets to 0 at the edge of any DCACHE_BUSY=0 cycle.
  - TIMEOUT sets when frz_cnt==MAX_FREEZE and DCACHE_BUSY=1, and stays set until RESET. TIMEOUT does not alter enables.
- No enable output is ever X. Simultaneous P1..P4 conditions are resolved only by the priority order above.

Optional Feature:
STALL_PERF_CNT_EN:
- Defined: 32-bit wrapping counters increment at the edge.
  - LU_STALL_CNT on P3 cycles.
  - FREEZE_TOTAL_CNT on P1 cycles.
  - FLUSH_CNT on P2 cycles.
  - Counters clear on RESET.
- Undefined: the three ports remain and are driven constant 0; no counter flops are synthesised.

Test Plan:
1. LOAD_USE_HAZARD=1 for 1 cycle, others 0 -> PC_EN=0, IF_ID_EN=0, ID_EX_BUBBLE=1 that cycle; next cycle all enables 1, BUBBLE=0; LU_STALL_CNT=1 with macro.
2. DCACHE_BUSY=1 for 3 cycles with LOAD_USE_HAZARD=1 and BRANCH_TAKEN_S3=1 -> all enables 0, FLUSH=0, BUBBLE=0 for 3 cycles; on the 4th cycle (busy=0) branch flush: IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_EN=1.
3. BRANCH_TAKEN_S3=1 with ICACHE_BUSY=1, then ICACHE_BUSY=1 for 2 more cycles, then 0 -> IF_ID_FLUSH=1 in all 4 cycles; flush_pending=0 after the 4th edge; 5th cycle IF_ID_FLUSH=0.
4. BRANCH_TAKEN_S3=1 and LOAD_USE_HAZARD=1 together -> PC_EN=1, IF_ID_EN=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1; FLUSH_CNT+1, LU_STALL_CNT unchanged.
5. MAX_FREEZE=4, DCACHE_BUSY=1 for 6 cycles -> TIMEOUT rises after the 5th busy edge and stays 1 after busy drops; a RESET pulse clears it.
6. RESET=1 asserted during a pending flush -> that cycle all enables 1, FLUSH=1, BUBBLE=1; after release flush_pending=0 and IF_ID_FLUSH follows inputs only.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
//------------------------------------------------------------------------------
// Module   : pipeline_stall_controller
// Desc     : Fixed-priority stall/flush/bubble control for the 5-stage CPU,
//            with wrong-path fetch tracking and a D-cache freeze watchdog.
//            Optional perf counters enabled by macro STALL_PERF_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_stall_controller #(
   parameter int MAX_FREEZE    = 255,
   parameter int FRZ_CNT_WIDTH = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        LOAD_USE_HAZARD,
   input  logic        BRANCH_TAKEN_S3,
   input  logic        ICACHE_BUSY,
   input  logic        DCACHE_BUSY,
   output logic        PC_EN,
   output logic        IF_ID_EN,
   output logic        ID_EX_EN,
   output logic        EX_MEM_EN,
   output logic        MEM_WB_EN,
   output logic        IF_ID_FLUSH,
   output logic        ID_EX_BUBBLE,
   output logic        TIMEOUT,
   output logic [31:0] LU_STALL_CNT,
   output logic [31:0] FREEZE_TOTAL_CNT,
   output logic [31:0] FLUSH_CNT
);

   localparam logic [FRZ_CNT_WIDTH-1:0] c_max_freeze = FRZ_CNT_WIDTH'(MAX_FREEZE);
   localparam logic [FRZ_CNT_WIDTH-1:0] c_frz_one    = FRZ_CNT_WIDTH'(1);

   logic                     r_flush_pending;
   logic [FRZ_CNT_WIDTH-1:0] r_frz_cnt;
   logic                     r_timeout;

   logic w_p1_freeze;
   logic w_p2_branch;
   logic w_p3_load_use;
   logic w_fp_set;
   logic w_fp_clear;

   assign w_p1_freeze   = DCACHE_BUSY;
   assign w_p2_branch   = ~DCACHE_BUSY & BRANCH_TAKEN_S3;
   assign w_p3_load_use = ~DCACHE_BUSY & ~BRANCH_TAKEN_S3 & LOAD_USE_HAZARD;
   assign w_fp_set      = w_p2_branch & ICACHE_BUSY;
   assign w_fp_clear    = ~ICACHE_BUSY & ~DCACHE_BUSY;

   always_comb begin
      PC_EN        = 1'b1;
      IF_ID_EN     = 1'b1;
      ID_EX_EN     = 1'b1;
      EX_MEM_EN    = 1'b1;
      MEM_WB_EN    = 1'b1;
      IF_ID_FLUSH  = 1'b0;
      ID_EX_BUBBLE = 1'b0;
      if (RESET) begin
         IF_ID_FLUSH  = 1'b1;
         ID_EX_BUBBLE = 1'b1;
      end else if (w_p1_freeze) begin
         PC_EN     = 1'b0;
         IF_ID_EN  = 1'b0;
         ID_EX_EN  = 1'b0;
         EX_MEM_EN = 1'b0;
         MEM_WB_EN = 1'b0;
      end else begin
         if (w_p2_branch) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
         end else if (w_p3_load_use) begin
            PC_EN        = 1'b0;
            IF_ID_EN     = 1'b0;
            ID_EX_BUBBLE = 1'b1;
         end else if (ICACHE_BUSY) begin
            PC_EN       = 1'b0;
            IF_ID_FLUSH = 1'b1;
         end
         // The fetch aborted by a taken branch still returns a wrong-path word.
         if (r_flush_pending) begin
            IF_ID_FLUSH = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_flush_pending <= 1'b0;
         r_frz_cnt       <= '0;
         r_timeout       <= 1'b0;
      end else begin
         if (w_fp_set) begin
            r_flush_pending <= 1'b1;
         end else if (w_fp_clear) begin
            r_flush_pending <= 1'b0;
         end
         if (DCACHE_BUSY) begin
            if (r_frz_cnt == c_max_freeze) begin
               r_timeout <= 1'b1;
            end else begin
               r_frz_cnt <= r_frz_cnt + c_frz_one;
            end
         end else begin
            r_frz_cnt <= '0;
         end
      end
   end

   assign TIMEOUT = r_timeout;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] r_lu_stall_cnt;
   logic [31:0] r_freeze_total_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_lu_stall_cnt     <= '0;
         r_freeze_total_cnt <= '0;
         r_flush_cnt        <= '0;
      end else begin
         if (w_p3_load_use) r_lu_stall_cnt     <= r_lu_stall_cnt + 32'd1;
         if (w_p1_freeze)   r_freeze_total_cnt <= r_freeze_total_cnt + 32'd1;
         if (w_p2_branch)   r_flush_cnt        <= r_flush_cnt + 32'd1;
      end
   end

   assign LU_STALL_CNT     = r_lu_stall_cnt;
   assign FREEZE_TOTAL_CNT = r_freeze_total_cnt;
   assign FLUSH_CNT        = r_flush_cnt;
`else
   assign LU_STALL_CNT     = 32'd0;
   assign FREEZE_TOTAL_CNT = 32'd0;
   assign FLUSH_CNT        = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_pipeline_stall_controller
// Desc     : Scoreboard bench for pipeline_stall_controller (MAX_FREEZE=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_stall_controller;

   localparam int c_max = 4;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        LOAD_USE_HAZARD = 1'b0;
   logic        BRANCH_TAKEN_S3 = 1'b0;
   logic        ICACHE_BUSY = 1'b0;
   logic        DCACHE_BUSY = 1'b0;
   logic        PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN;
   logic        IF_ID_FLUSH, ID_EX_BUBBLE, TIMEOUT;
   logic [31:0] LU_STALL_CNT, FREEZE_TOTAL_CNT, FLUSH_CNT;

   int n_checks = 0;
   int n_errors = 0;

   // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB enables, FLUSH, BUBBLE, TIMEOUT}
   logic [7:0] exp_q[$];

   logic        m_fp = 1'b0;
   int          m_cnt = 0;
   logic        m_to = 1'b0;
   logic [31:0] m_lu = '0, m_frz = '0, m_fl = '0;

   pipeline_stall_controller #(.MAX_FREEZE(c_max), .FRZ_CNT_WIDTH(8)) dut (
      .CLK(CLK), .RESET(RESET), .LOAD_USE_HAZARD(LOAD_USE_HAZARD),
      .BRANCH_TAKEN_S3(BRANCH_TAKEN_S3), .ICACHE_BUSY(ICACHE_BUSY),
      .DCACHE_BUSY(DCACHE_BUSY), .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN),
      .ID_EX_EN(ID_EX_EN), .EX_MEM_EN(EX_MEM_EN), .MEM_WB_EN(MEM_WB_EN),
      .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_BUBBLE(ID_EX_BUBBLE), .TIMEOUT(TIMEOUT),
      .LU_STALL_CNT(LU_STALL_CNT), .FREEZE_TOTAL_CNT(FREEZE_TOTAL_CNT),
      .FLUSH_CNT(FLUSH_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle (from negedge), push the expected result, sample before
   // the rising edge, then advance the reference state across the edge.
   task automatic step(input logic rst, input logic lu, input logic br,
                       input logic ic, input logic dc, input string tag);
      logic [6:0] e;
      logic [7:0] got, exp;
      RESET = rst; LOAD_USE_HAZARD = lu; BRANCH_TAKEN_S3 = br;
      ICACHE_BUSY = ic; DCACHE_BUSY = dc;
      if (rst)      e = 7'b11111_11;
      else if (dc)  e = 7'b00000_00;
      else if (br)  e = 7'b11111_11;
      else if (lu)  e = 7'b00111_01;
      else if (ic)  e = 7'b01111_10;
      else          e = 7'b11111_00;
      if (!rst && !dc && m_fp) e[1] = 1'b1;
      exp_q.push_back({e, m_to});
      #4;
      got = {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_BUBBLE, TIMEOUT};
      exp = exp_q.pop_front();
      check({tag, ":ctl"}, {24'd0, got}, {24'd0, exp});
`ifdef STALL_PERF_CNT_EN
      check({tag, ":lu_cnt"}, LU_STALL_CNT, m_lu);
      check({tag, ":frz_cnt"}, FREEZE_TOTAL_CNT, m_frz);
      check({tag, ":flush_cnt"}, FLUSH_CNT, m_fl);
`else
      check({tag, ":lu_cnt"}, LU_STALL_CNT, 32'd0);
      check({tag, ":frz_cnt"}, FREEZE_TOTAL_CNT, 32'd0);
      check({tag, ":flush_cnt"}, FLUSH_CNT, 32'd0);
`endif
      @(posedge CLK);
      if (rst) begin
         m_fp = 1'b0; m_cnt = 0; m_to = 1'b0; m_lu = '0; m_frz = '0; m_fl = '0;
      end else begin
         if (!dc && br && ic) m_fp = 1'b1;
         else if (!dc && !ic) m_fp = 1'b0;
         if (dc) begin
            if (m_cnt == c_max) m_to = 1'b1;
            else m_cnt++;
            m_frz++;
         end else begin
            m_cnt = 0;
            if (br) m_fl++;
            else if (lu) m_lu++;
         end
      end
      @(negedge CLK);
   endtask

   initial begin
      @(posedge CLK);
      @(negedge CLK);
      step(1, 0, 0, 0, 0, "reset");
      step(0, 0, 0, 0, 0, "idle");
      // load-use single bubble
      step(0, 1, 0, 0, 0, "lu");
      step(0, 0, 0, 0, 0, "lu_after");
      // freeze masks branch and load-use, branch serviced on release
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, "frz_mask");
      step(0, 1, 1, 0, 0, "frz_release");
      step(0, 0, 0, 0, 0, "idle2");
      // branch behind I-cache miss
      step(0, 0, 1, 1, 0, "br_ic");
      step(0, 0, 0, 1, 0, "pend1");
      step(0, 0, 0, 1, 0, "pend2");
      step(0, 0, 0, 0, 0, "pend_clear");
      step(0, 0, 0, 0, 0, "pend_done");
      // branch beats load-use
      step(0, 1, 1, 0, 0, "br_lu");
      step(0, 0, 0, 0, 0, "idle3");
      // watchdog: 6 freeze cycles with MAX_FREEZE=4
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, "wdog");
      step(0, 0, 0, 0, 0, "wdog_sticky");
      step(0, 1, 0, 0, 0, "wdog_sticky_lu");
      check("timeout_set", {31'd0, TIMEOUT}, 32'd1);
      step(1, 0, 0, 0, 0, "wdog_reset");
      step(0, 0, 0, 0, 0, "wdog_cleared");
      // reset during pending flush
      step(0, 0, 1, 1, 0, "pend_set");
      step(0, 0, 0, 1, 1, "pend_frz");
      step(1, 0, 0, 1, 0, "pend_reset");
      step(0, 0, 0, 0, 0, "pend_gone");
      step(0, 1, 0, 1, 0, "lu_ic");
      // random mix
      for (int i = 0; i < 200; i++)
         step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom), 1'($urandom_range(0, 2) == 0), "rand");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
